// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the instruction-ROM port controller.
// Holds the state encoding, the owner encoding, and the word/counter sizing.
package imem_ctrl_pkg;

  // Bytes per assembled 32-bit word and the width of the byte counter.
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CNT_W      = 2;

  // Sequencer states as plain constants so they map onto older tools unchanged.
  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StIssue = 2'd1;
  localparam state_t StDrain = 2'd2;
  localparam state_t StResp  = 2'd3;

  // Which requester owns the transaction currently in flight.
  typedef enum logic {
    OwnFetch = 1'b0,
    OwnData  = 1'b1
  } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter for the ROM port.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   fetch_req_i   fetch-side request
//   data_req_i    data-side request
//   accept_i      the sequencer takes the current grant this cycle
//   gnt_o         one-hot grant, bit 0 = fetch, bit 1 = data (combinational)
//   owner_o       last granted requester; also the owner of the live transaction
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fetch_req_i,
  input  logic       data_req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o,
  output logic       owner_o
);
  import imem_ctrl_pkg::*;

  owner_e owner_q;

  // On a tie, serve whichever requester was not served last.
  always_comb begin
    gnt_o = 2'b00;
    if (fetch_req_i && data_req_i) begin
      gnt_o = (owner_q == OwnData) ? 2'b01 : 2'b10;
    end else if (fetch_req_i) begin
      gnt_o = 2'b01;
    end else if (data_req_i) begin
      gnt_o = 2'b10;
    end
  end

  // Reset to data so fetch wins the very first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OwnData;
    end else if (accept_i && (gnt_o != 2'b00)) begin
      owner_q <= gnt_o[1] ? OwnData : OwnFetch;
    end
  end

  assign owner_o = owner_q;

endmodule

// File: rtl/imem_port_ctrl.sv
// Shares the byte-wide synchronous instruction ROM between fetch and data-side
// 32-bit reads. Each granted request issues four consecutive byte reads and
// assembles them big-endian (byte at the base address is the MSB).
// Ports:
//   clk, rst_n                     clock and asynchronous active-low reset
//   fetch_req_i / fetch_addr_i     fetch request and byte address
//   fetch_rvalid_o / fetch_rdata_o one-cycle response pulse and held word
//   data_req_i / data_addr_i       data-side request and byte address
//   data_rvalid_o / data_rdata_o   one-cycle response pulse and held word
//   mem_en_o / mem_addr_o          ROM read enable and byte address
//   mem_rdata_i                    ROM byte, valid the cycle after mem_en_o
//   busy_o                         high whenever a transaction is in progress
module imem_port_ctrl #(
  parameter int unsigned A_WIDTH = 32,
  parameter int unsigned D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_req_i,
  input  logic [A_WIDTH-1:0] fetch_addr_i,
  output logic               fetch_rvalid_o,
  output logic [31:0]        fetch_rdata_o,
  input  logic               data_req_i,
  input  logic [A_WIDTH-1:0] data_addr_i,
  output logic               data_rvalid_o,
  output logic [31:0]        data_rdata_o,
  output logic               mem_en_o,
  output logic [A_WIDTH-1:0] mem_addr_o,
  input  logic [D_WIDTH-1:0] mem_rdata_i,
  output logic               busy_o
);
  import imem_ctrl_pkg::*;

  // Only the leading bytes need storing; the last byte is merged straight
  // into the owner's rdata register in DRAIN.
  localparam int unsigned PartW = 32 - D_WIDTH;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [A_WIDTH-1:0] base_q, base_d;
  logic [PartW-1:0]   word_q, word_d;
  logic [31:0]        fetch_rdata_q, fetch_rdata_d;
  logic [31:0]        data_rdata_q, data_rdata_d;

  logic [1:0] gnt;
  logic       owner;
  logic       accept;

  assign accept = (state_q == StIdle);

  rr_arb2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req_i(fetch_req_i),
    .data_req_i (data_req_i),
    .accept_i   (accept),
    .gnt_o      (gnt),
    .owner_o    (owner)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    base_d        = base_q;
    word_d        = word_q;
    fetch_rdata_d = fetch_rdata_q;
    data_rdata_d  = data_rdata_q;

    case (state_q)
      StIdle: begin
        if (gnt != 2'b00) begin
          state_d = StIssue;
          cnt_d   = '0;
          base_d  = gnt[1] ? data_addr_i : fetch_addr_i;
        end
      end
      StIssue: begin
        // ROM data lags the address by one cycle, so nothing arrives on cnt=0.
        if (cnt_q != '0) begin
          word_d = {word_q[PartW-D_WIDTH-1:0], mem_rdata_i};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WORD_BYTES - 1)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        word_d = '0;
        if (owner == OwnData) begin
          data_rdata_d = {word_q, mem_rdata_i};
        end else begin
          fetch_rdata_d = {word_q, mem_rdata_i};
        end
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      base_q        <= '0;
      word_q        <= '0;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      base_q        <= base_d;
      word_q        <= word_d;
      fetch_rdata_q <= fetch_rdata_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  // Address wraps modulo 2^A_WIDTH by plain truncation.
  assign mem_en_o       = (state_q == StIssue);
  assign mem_addr_o     = mem_en_o ? (base_q + A_WIDTH'(cnt_q)) : '0;
  assign fetch_rvalid_o = (state_q == StResp) && (owner == OwnFetch);
  assign data_rvalid_o  = (state_q == StResp) && (owner == OwnData);
  assign fetch_rdata_o  = fetch_rdata_q;
  assign data_rdata_o   = data_rdata_q;
  assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_imem_port_ctrl.sv
// Self-checking bench for imem_port_ctrl: a table of directed transactions,
// a reset-during-transaction sequence, then randomized transactions checked
// against a word-level reference model of the ROM and the arbitration rule.
module tb_imem_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req_i, data_req_i;
  logic [31:0] fetch_addr_i, data_addr_i;
  logic        fetch_rvalid_o, data_rvalid_o;
  logic [31:0] fetch_rdata_o, data_rdata_o;
  logic        mem_en_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_rdata_i;
  logic        busy_o;

  always #5 clk = ~clk;

  imem_port_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_req_i   (fetch_req_i),
    .fetch_addr_i  (fetch_addr_i),
    .fetch_rvalid_o(fetch_rvalid_o),
    .fetch_rdata_o (fetch_rdata_o),
    .data_req_i    (data_req_i),
    .data_addr_i   (data_addr_i),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .mem_en_o      (mem_en_o),
    .mem_addr_o    (mem_addr_o),
    .mem_rdata_i   (mem_rdata_i),
    .busy_o        (busy_o)
  );

  // ROM contents: a few fixed bytes, everything else a hash of the address.
  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 8'h00;
      32'h0000_0001: return 8'h50;
      32'h0000_0002: return 8'h06;
      32'h0000_0003: return 8'h93;
      32'h0000_0004: return 8'h13;
      32'h0000_0100: return 8'hDE;
      32'h0000_0101: return 8'hAD;
      32'h0000_0102: return 8'hBE;
      32'h0000_0103: return 8'hEF;
      32'hFFFF_FFFE: return 8'h11;
      32'hFFFF_FFFF: return 8'h22;
      default:       return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_en_o) mem_rdata_i <= rom_byte(mem_addr_o);
  end

  function automatic logic [31:0] ref_word(input logic [31:0] b);
    return {rom_byte(b), rom_byte(b + 32'd1), rom_byte(b + 32'd2), rom_byte(b + 32'd3)};
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 2))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 263));
      default: return 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
    endcase
  endfunction

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] last_fetch, last_data;
  logic        model_last_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy_o && i < 30) begin
      @(negedge clk);
      i++;
    end
    if (busy_o) check("wait_idle_timeout", 32'(busy_o), 32'd0);
  endtask

  typedef struct {
    logic        fr;
    logic [31:0] fa;
    logic        dr;
    logic [31:0] da;
    logic        exp_fetch;
    logic [31:0] exp_word;
    logic        hold;
  } vec_t;

  // Called at a negedge. One full transaction, checked cycle by cycle.
  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] base;
    logic [31:0] exp_rv;
    base   = v.exp_fetch ? v.fa : v.da;
    exp_rv = v.exp_fetch ? 32'd2 : 32'd1;
    wait_idle();
    fetch_req_i  = v.fr;
    fetch_addr_i = v.fa;
    data_req_i   = v.dr;
    data_addr_i  = v.da;
    @(posedge clk);
    @(negedge clk);
    if (v.hold) begin
      // Requests stay up, addresses move: the latched base must be used.
      fetch_addr_i = $urandom;
      data_addr_i  = $urandom;
    end else begin
      fetch_req_i = 1'b0;
      data_req_i  = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      check({tag, "/issue_en"}, 32'(mem_en_o), 32'd1);
      check({tag, "/issue_addr"}, mem_addr_o, base + 32'(k));
      check({tag, "/issue_rvalid"}, 32'({fetch_rvalid_o, data_rvalid_o}), 32'd0);
      @(negedge clk);
    end
    check({tag, "/drain_en"}, 32'(mem_en_o), 32'd0);
    check({tag, "/drain_addr"}, mem_addr_o, 32'd0);
    check({tag, "/drain_busy"}, 32'(busy_o), 32'd1);
    @(negedge clk);
    check({tag, "/resp_rvalid"}, 32'({fetch_rvalid_o, data_rvalid_o}), exp_rv);
    if (v.exp_fetch) begin
      check({tag, "/resp_fetch_rdata"}, fetch_rdata_o, v.exp_word);
      check({tag, "/other_data_rdata_held"}, data_rdata_o, last_data);
      last_fetch = v.exp_word;
    end else begin
      check({tag, "/resp_data_rdata"}, data_rdata_o, v.exp_word);
      check({tag, "/other_fetch_rdata_held"}, fetch_rdata_o, last_fetch);
      last_data = v.exp_word;
    end
    fetch_req_i     = 1'b0;
    data_req_i      = 1'b0;
    model_last_data = !v.exp_fetch;
    @(negedge clk);
    check({tag, "/after_rvalid"}, 32'({fetch_rvalid_o, data_rvalid_o}), 32'd0);
    check({tag, "/after_busy"}, 32'(busy_o), 32'd0);
    check({tag, "/after_hold"}, v.exp_fetch ? fetch_rdata_o : data_rdata_o, v.exp_word);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/ctl"}, 32'({fetch_rvalid_o, data_rvalid_o, mem_en_o, busy_o}), 32'd0);
    check({tag, "/mem_addr"}, mem_addr_o, 32'd0);
    check({tag, "/fetch_rdata"}, fetch_rdata_o, 32'd0);
    check({tag, "/data_rdata"}, data_rdata_o, 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 32'h0,         1'b1, 32'h100, 1'b1, 32'h0050_0693, 1'b1};
    vecs[1] = '{1'b1, 32'h4,         1'b1, 32'h100, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b1, 32'h0,         1'b1, 32'h4,   1'b1, 32'h0050_0693, 1'b0};
    vecs[3] = '{1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0,   1'b1, 32'h1122_0050, 1'b0};
    vecs[4] = '{1'b0, 32'h0,         1'b1, 32'h1,   1'b0, 32'h5006_9313, 1'b0};
    vecs[5] = '{1'b1, 32'h1,         1'b0, 32'h0,   1'b1, 32'h5006_9313, 1'b1};
    vecs[6] = '{1'b1, 32'h100,       1'b1, 32'h0,   1'b0, 32'h0050_0693, 1'b0};
    vecs[7] = '{1'b1, 32'h100,       1'b1, 32'h2,   1'b1, 32'hDEAD_BEEF, 1'b0};

    rst_n           = 1'b0;
    fetch_req_i     = 1'b0;
    data_req_i      = 1'b0;
    fetch_addr_i    = '0;
    data_addr_i     = '0;
    last_fetch      = '0;
    last_data       = '0;
    model_last_data = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted mid-ISSUE (cnt=2): everything clears at once, no late rvalid.
    wait_idle();
    fetch_req_i  = 1'b1;
    fetch_addr_i = 32'h0;
    @(posedge clk);
    @(negedge clk);
    fetch_req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst/cnt2_addr", mem_addr_o, 32'h2);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst_async");
    @(negedge clk);
    @(negedge clk);
    rst_n           = 1'b1;
    last_fetch      = '0;
    last_data       = '0;
    model_last_data = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst/no_rvalid", 32'({fetch_rvalid_o, data_rvalid_o, busy_o}), 32'd0);
    end
    begin
      vec_t v;
      v = '{1'b1, 32'h0, 1'b1, 32'h100, 1'b1, 32'h0050_0693, 1'b0};
      run_vec(v, "post_reset_tie");
    end

    // Randomized transactions against the word-level model.
    for (int n = 0; n < 30; n++) begin
      vec_t v;
      logic [1:0] r;
      r           = 2'($urandom_range(1, 3));
      v.fr        = r[0];
      v.dr        = r[1];
      v.fa        = pick_addr();
      v.da        = pick_addr();
      v.exp_fetch = v.fr && (!v.dr || model_last_data);
      v.exp_word  = ref_word(v.exp_fetch ? v.fa : v.da);
      v.hold      = 1'($urandom_range(0, 1));
      run_vec(v, $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
